timer_tick_scheduler: RTL and testbench

Avalon-MM master that owns the system interval timer: it programs the period, starts the timer in continuous mode with interrupts enabled, services each timeout interrupt by clearing the timer status, and fans each tick out to NUM_CH software-programmable down-counting channels. It sits between the interval timer's 16-bit register slave and the fabric blocks that need periodic events, so that no CPU involvement is required per tick.

---
 rtl/timer_tick_scheduler.sv | 143 ++++++++++++++
 tb/tb_timer_tick_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_scheduler.sv
// Interval-timer master: programs and services the system timer, fanning each tick out to down-counting channels.
// Optional TICK_SCHED_OVERRUN_EN adds the sticky ch_overrun output.
module timer_tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic [31:0]             cfg_period,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*CNT_W-1:0] ch_reload,
  input  logic [NUM_CH-1:0]       ch_ack,
  input  logic                    timer_irq,
  output logic [2:0]              m_address,
  output logic                    m_chipselect,
  output logic                    m_write_n,
  output logic [15:0]             m_writedata,
  output logic                    busy,
  output logic [NUM_CH-1:0]       ch_pending,
  output logic [31:0]             tick_count
`ifdef TICK_SCHED_OVERRUN_EN
  ,
  output logic [NUM_CH-1:0]       ch_overrun
`endif
);

  typedef enum logic [2:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, TICK, WR_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       period_q;
  logic              stop_pend;
  logic [CNT_W-1:0]  counter [NUM_CH];
  logic              start_acc;
  logic              tick;

  assign start_acc = (state == IDLE) && cfg_start;
  assign tick      = (state == TICK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // An IRQ seen in RUN is always serviced before a pending stop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = WR_PL;
      WR_PL:   state_nxt = WR_PH;
      WR_PH:   state_nxt = WR_CTRL;
      WR_CTRL: state_nxt = RUN;
      RUN: begin
        if (timer_irq)      state_nxt = CLR;
        else if (stop_pend) state_nxt = WR_STOP;
      end
      CLR:     state_nxt = TICK;
      TICK:    state_nxt = RUN;
      WR_STOP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = 3'd0;
    m_writedata  = 16'h0000;
    busy         = (state != IDLE);
    case (state)
      WR_PL: begin
        m_chipselect = 1'b1; m_write_n = 1'b0;
        m_address = 3'd2; m_writedata = period_q[15:0];
      end
      WR_PH: begin
        m_chipselect = 1'b1; m_write_n = 1'b0;
        m_address = 3'd3; m_writedata = period_q[31:16];
      end
      WR_CTRL: begin
        m_chipselect = 1'b1; m_write_n = 1'b0;
        m_address = 3'd1; m_writedata = 16'h0007;
      end
      CLR: begin
        m_chipselect = 1'b1; m_write_n = 1'b0;
        m_address = 3'd0; m_writedata = 16'h0000;
      end
      WR_STOP: begin
        m_chipselect = 1'b1; m_write_n = 1'b0;
        m_address = 3'd1; m_writedata = 16'h0008;
      end
      default: ;
    endcase
  end

  // A channel expiry in TICK takes priority over a same-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q   <= 32'd0;
      tick_count <= 32'd0;
      stop_pend  <= 1'b0;
      ch_pending <= '0;
`ifdef TICK_SCHED_OVERRUN_EN
      ch_overrun <= '0;
`endif
      for (int i = 0; i < NUM_CH; i++) counter[i] <= '0;
    end else begin
      if (state == WR_STOP)                 stop_pend <= 1'b0;
      else if (cfg_stop && state != IDLE)   stop_pend <= 1'b1;

      if (start_acc) begin
        period_q   <= cfg_period;
        tick_count <= 32'd0;
        ch_pending <= '0;
`ifdef TICK_SCHED_OVERRUN_EN
        ch_overrun <= '0;
`endif
        for (int i = 0; i < NUM_CH; i++) counter[i] <= ch_reload[i*CNT_W +: CNT_W];
      end else begin
        if (tick) tick_count <= tick_count + 32'd1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (tick && ch_enable[i]) begin
            if (counter[i] == '0) begin
              counter[i]    <= ch_reload[i*CNT_W +: CNT_W];
              ch_pending[i] <= 1'b1;
`ifdef TICK_SCHED_OVERRUN_EN
              if (ch_pending[i] && !ch_ack[i]) ch_overrun[i] <= 1'b1;
`endif
            end else begin
              counter[i] <= counter[i] - CNT_W'(1);
              if (ch_ack[i]) ch_pending[i] <= 1'b0;
            end
          end else if (ch_ack[i]) begin
            ch_pending[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed self-checking bench for timer_tick_scheduler, with a small behavioural interval timer.
// Honours TICK_SCHED_OVERRUN_EN to exercise the optional ch_overrun output.
module tb_timer_tick_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic [3:0]  ch_enable = 4'd0;
  logic [63:0] ch_reload = 64'd0;
  logic [3:0]  ch_ack = 4'd0;
  logic        timer_irq;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic        busy;
  logic [3:0]  ch_pending;
  logic [31:0] tick_count;
`ifdef TICK_SCHED_OVERRUN_EN
  logic [3:0]  ch_overrun;
`endif

  logic        use_model = 1'b0;
  logic        man_irq = 1'b0;
  logic        model_irq;
  int          checks = 0;
  int          errors = 0;

  localparam logic [20:0] BUS_IDLE = {1'b0, 1'b1, 3'd0, 16'h0000};

  assign timer_irq = use_model ? model_irq : man_irq;

  timer_tick_scheduler #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_period(cfg_period), .ch_enable(ch_enable), .ch_reload(ch_reload),
    .ch_ack(ch_ack), .timer_irq(timer_irq), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_write_n(m_write_n), .m_writedata(m_writedata),
    .busy(busy), .ch_pending(ch_pending), .tick_count(tick_count)
`ifdef TICK_SCHED_OVERRUN_EN
    , .ch_overrun(ch_overrun)
`endif
  );

  always #5 clk = ~clk;

  // Interval timer: counts period..0 in continuous mode, TO is cleared by a status write.
  logic [15:0] t_pl, t_ph;
  logic [31:0] t_cnt;
  logic        t_run, t_to, t_ito;
  assign model_irq = t_to && t_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_pl <= 16'd0; t_ph <= 16'd0; t_cnt <= 32'd0;
      t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
    end else if (m_chipselect && !m_write_n) begin
      case (m_address)
        3'd0: t_to <= 1'b0;
        3'd2: t_pl <= m_writedata;
        3'd3: t_ph <= m_writedata;
        3'd1: begin
          t_ito <= m_writedata[0];
          if (m_writedata[2]) begin t_run <= 1'b1; t_cnt <= {t_ph, t_pl}; end
          if (m_writedata[3]) t_run <= 1'b0;
        end
        default: ;
      endcase
    end else if (t_run) begin
      if (t_cnt == 32'd0) begin t_to <= 1'b1; t_cnt <= {t_ph, t_pl}; end
      else t_cnt <= t_cnt - 32'd1;
    end
  end

  function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
    return {1'b1, 1'b0, a, d};
  endfunction

  function automatic logic [20:0] bus_now();
    return {m_chipselect, m_write_n, m_address, m_writedata};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of control inputs, then sample just after the edge.
  task automatic applyStimulus(input logic start, input logic stop, input logic irq);
    cfg_start = start;
    cfg_stop  = stop;
    man_irq   = irq;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    man_irq   = 1'b0;
  endtask

  task automatic startToRun(input logic [31:0] period);
    cfg_period = period;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic doTick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic stopToIdle(input string tag);
    int n;
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while (busy && n < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] exp_p;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_bus", bus_now(), BUS_IDLE);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_pending", {28'd0, ch_pending}, 32'd0);
    checkOutput("reset_ticks", tick_count, 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Programming sequence, then stop from RUN.
    cfg_period = 32'h0001_86A0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("prog_pl", bus_now(), wr(3'd2, 16'h86A0));
    checkOutput("prog_busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("prog_ph", bus_now(), wr(3'd3, 16'h0001));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("prog_ctrl", bus_now(), wr(3'd1, 16'h0007));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("prog_run_bus", bus_now(), BUS_IDLE);
    checkOutput("prog_run_busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_wait", bus_now(), BUS_IDLE);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stop_write", bus_now(), wr(3'd1, 16'h0008));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stop_idle", {31'd0, busy}, 32'd0);

    // Stop requested while programming is only honoured once RUN is reached.
    cfg_period = 32'd50;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("early_stop_ctrl", bus_now(), wr(3'd1, 16'h0007));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("early_stop_run", bus_now(), BUS_IDLE);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("early_stop_write", bus_now(), wr(3'd1, 16'h0008));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("early_stop_idle", {31'd0, busy}, 32'd0);
    checkOutput("early_stop_bus", bus_now(), BUS_IDLE);

    // Stop in IDLE does nothing and does not linger into the next run.
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("idle_stop_bus", bus_now(), BUS_IDLE);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    startToRun(32'd50);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_stop_no_linger", bus_now(), BUS_IDLE);
    checkOutput("idle_stop_still_busy", {31'd0, busy}, 32'd1);
    stopToIdle("idle_stop_cleanup");

    // Five interrupts from the timer model with period 9.
    use_model = 1'b1;
    startToRun(32'd9);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!timer_irq && n < 40) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        n++;
      end
      checkOutput("irq_seen", {31'd0, timer_irq}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("irq_clr_write", bus_now(), wr(3'd0, 16'h0000));
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("irq_dropped", {31'd0, timer_irq}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("irq_tick_count", tick_count, 32'd5);
    stopToIdle("irq_stop");
    use_model = 1'b0;

    // Channel 0 reload 2, channel 1 reload 0; ack after each check.
    ch_reload = {16'd0, 16'd0, 16'd0, 16'd2};
    ch_enable = 4'b0011;
    startToRun(32'd100);
    checkOutput("ch_start_pending", {28'd0, ch_pending}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      doTick();
      exp_p = {2'b00, 1'b1, (k % 3 == 0)};
      checkOutput($sformatf("ch_tick%0d", k), {28'd0, ch_pending}, {28'd0, exp_p});
      ch_ack = 4'b0011;
      applyStimulus(1'b0, 1'b0, 1'b0);
      ch_ack = 4'b0000;
      checkOutput($sformatf("ch_ack%0d", k), {28'd0, ch_pending}, 32'd0);
    end
    checkOutput("ch_tick_count", tick_count, 32'd6);
    // Ack held through an expiry on channel 1: the set wins.
    ch_ack = 4'b0010;
    doTick();
    ch_ack = 4'b0000;
    checkOutput("ch_set_beats_ack", {28'd0, ch_pending}, 32'h2);

    // cfg_start while running is ignored.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("busy_start_bus", bus_now(), BUS_IDLE);
    checkOutput("busy_start_ticks", tick_count, 32'd7);
    stopToIdle("ch_stop");

    // IRQ and stop in the same RUN cycle: service first, then stop.
    ch_enable = 4'b0000;
    startToRun(32'd100);
    checkOutput("col_start_ticks", tick_count, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("col_clr", bus_now(), wr(3'd0, 16'h0000));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("col_tick_bus", bus_now(), BUS_IDLE);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("col_ticks", tick_count, 32'd1);
    checkOutput("col_run_bus", bus_now(), BUS_IDLE);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("col_stop_write", bus_now(), wr(3'd1, 16'h0008));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("col_idle", {31'd0, busy}, 32'd0);

`ifdef TICK_SCHED_OVERRUN_EN
    ch_reload = 64'd0;
    ch_enable = 4'b0001;
    startToRun(32'd100);
    doTick();
    checkOutput("ovr_first", {28'd0, ch_overrun}, 32'd0);
    doTick();
    checkOutput("ovr_second", {28'd0, ch_overrun}, 32'd1);
    stopToIdle("ovr_stop");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
